// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refills and
// D-cache refills/write-backs; each grant lasts one full block burst.
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          ic_req_i,
  input  logic [ADDR_WIDTH-1:0]         ic_addr_i,
  output logic                          ic_rvalid_o,
  output logic [DATA_WIDTH-1:0]         ic_rdata_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] ic_word_o,
  output logic                          ic_done_o,
  input  logic                          dc_req_i,
  input  logic                          dc_we_i,
  input  logic [ADDR_WIDTH-1:0]         dc_addr_i,
  input  logic [DATA_WIDTH-1:0]         dc_wdata_i,
  output logic                          dc_rvalid_o,
  output logic [DATA_WIDTH-1:0]         dc_rdata_o,
  output logic [$clog2(BLOCK_WORDS)-1:0] dc_word_o,
  output logic                          dc_done_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic                          mem_ready_i,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i,
  output logic                          busy_o
);

  localparam int WI     = $clog2(BLOCK_WORDS);
  localparam int BYTE_W = $clog2(DATA_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK =
    ~ADDR_WIDTH'(BLOCK_WORDS * DATA_WIDTH / 8 - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_I_RD = 3'd1;
  localparam logic [2:0] S_D_RD = 3'd2;
  localparam logic [2:0] S_D_WR = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [WI-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  // Last grantee: 1 = D-cache, 0 = I-cache; also identifies who gets done.
  logic                  gnt_d_q, gnt_d_d;

  logic                  burst, ic_gnt, dc_gnt;
  logic [ADDR_WIDTH-1:0] beat_off;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    gnt_d_d = gnt_d_q;
    case (state_q)
      S_IDLE: begin
        if (dc_req_i && (!ic_req_i || !gnt_d_q)) begin
          state_d = dc_we_i ? S_D_WR : S_D_RD;
          base_d  = dc_addr_i & BLK_MASK;
          gnt_d_d = 1'b1;
          cnt_d   = '0;
        end else if (ic_req_i) begin
          state_d = S_I_RD;
          base_d  = ic_addr_i & BLK_MASK;
          gnt_d_d = 1'b0;
          cnt_d   = '0;
        end
      end
      S_I_RD, S_D_RD, S_D_WR: begin
        if (mem_ready_i) begin
          cnt_d = cnt_q + 1'b1;
          if (&cnt_q) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      gnt_d_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      gnt_d_q <= gnt_d_d;
    end
  end

  always_comb begin
    burst  = (state_q == S_I_RD) || (state_q == S_D_RD) || (state_q == S_D_WR);
    ic_gnt = (state_q == S_I_RD);
    dc_gnt = (state_q == S_D_RD) || (state_q == S_D_WR);
    // Base is block-aligned, so OR-ing in the word offset never carries.
    beat_off = '0;
    beat_off[BYTE_W +: WI] = cnt_q;

    mem_req_o   = burst;
    mem_we_o    = (state_q == S_D_WR);
    mem_addr_o  = burst ? (base_q | beat_off) : '0;
    mem_wdata_o = (state_q == S_D_WR) ? dc_wdata_i : '0;

    ic_rvalid_o = ic_gnt && mem_ready_i;
    ic_rdata_o  = ic_gnt ? mem_rdata_i : '0;
    ic_word_o   = ic_gnt ? cnt_q : '0;
    ic_done_o   = (state_q == S_DONE) && !gnt_d_q;

    dc_rvalid_o = (state_q == S_D_RD) && mem_ready_i;
    dc_rdata_o  = (state_q == S_D_RD) ? mem_rdata_i : '0;
    dc_word_o   = dc_gnt ? cnt_q : '0;
    dc_done_o   = (state_q == S_DONE) && gnt_d_q;

    busy_o = (state_q != S_IDLE);
  end

endmodule
